// File: rtl/display_source_arbiter.sv
// Round-robin owner of the seven-segment display: each owner keeps the display for a
// minimum dwell under contention and is replaced at once when it drops its request.
module display_source_arbiter #(
   parameter int NUM_SOURCES  = 4,
   parameter int DWELL_CYCLES = 100000000
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_SOURCES-1:0]           request,
   input  logic [16*NUM_SOURCES-1:0]        sourceData,
   input  logic [4*NUM_SOURCES-1:0]         sourcePoints,
   input  logic                             hold,
   output logic [15:0]                      displayData,
   output logic [3:0]                       displayPoints,
   output logic [NUM_SOURCES-1:0]           grant,
   output logic [$clog2(NUM_SOURCES)-1:0]   grantIndex,
   output logic                             switchPulse
);

   localparam int IDX_W = $clog2(NUM_SOURCES);
   localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
   localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_SOURCES - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_OWNED = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [CNT_W-1:0]       dwell_q, dwell_d;
   logic [NUM_SOURCES-1:0] grant_q, grant_d;
   logic [15:0]            data_q, data_d;
   logic [3:0]             points_q, points_d;
   logic                   pulse_q, pulse_d;

   logic [NUM_SOURCES-1:0] cand_s;
   logic [IDX_W-1:0]       pick_s;
   logic                   pick_found_s;
   logic                   win_s;
   logic                   owner_req_s;
   logic                   take_s;
   logic                   sel_s;
   int                     dist_s;
   int                     best_s;

   // Nearest requester after last_q; the current owner is masked out, so last_q itself
   // (distance NUM_SOURCES) can only be picked again when coming out of idle.
   always_comb begin
      cand_s       = request & ~grant_q;
      pick_s       = '0;
      pick_found_s = 1'b0;
      win_s        = 1'b0;
      best_s       = NUM_SOURCES + 1;
      dist_s       = 0;
      for (int j = 0; j < NUM_SOURCES; j++) begin
         dist_s       = (j - int'(last_q) + NUM_SOURCES) % NUM_SOURCES;
         dist_s       = (dist_s == 0) ? NUM_SOURCES : dist_s;
         win_s        = cand_s[j] && (dist_s < best_s);
         best_s       = win_s ? dist_s : best_s;
         pick_s       = win_s ? IDX_W'(j) : pick_s;
         pick_found_s = pick_found_s | win_s;
      end
   end

   // Ownership state, dwell counter and round-robin pointer next-state.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      dwell_d     = dwell_q;
      take_s      = 1'b0;
      owner_req_s = |(request & grant_q);
      case (state_q)
         S_IDLE: begin
            take_s = pick_found_s;
         end
         S_OWNED: begin
            if (!owner_req_s) begin
               take_s  = pick_found_s;
               state_d = S_IDLE;
               owner_d = '0;
               dwell_d = '0;
            end else if ((dwell_q == DWELL_MAX) && !hold && pick_found_s) begin
               take_s = 1'b1;
            end else if (dwell_q != DWELL_MAX) begin
               dwell_d = dwell_q + CNT_W'(1);
            end else begin
               dwell_d = dwell_q;
            end
         end
         default: begin
            state_d = S_IDLE;
            owner_d = '0;
            dwell_d = '0;
         end
      endcase
      if (take_s) begin
         state_d = S_OWNED;
         owner_d = pick_s;
         last_d  = pick_s;
         dwell_d = '0;
      end else begin
         last_d = last_q;
      end
   end

   // Next-cycle display outputs follow the next owner's slices; all zero when idle.
   always_comb begin
      grant_d  = '0;
      data_d   = '0;
      points_d = '0;
      sel_s    = 1'b0;
      for (int j = 0; j < NUM_SOURCES; j++) begin
         sel_s      = (state_d == S_OWNED) && (owner_d == IDX_W'(j));
         grant_d[j] = sel_s;
         data_d     = data_d | ({16{sel_s}} & sourceData[16*j +: 16]);
         points_d   = points_d | ({4{sel_s}} & sourcePoints[4*j +: 4]);
      end
      pulse_d = (grant_d != grant_q);
   end

   // State and registered outputs; reset overrides every request.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         owner_q  <= '0;
         last_q   <= LAST_INIT;
         dwell_q  <= '0;
         grant_q  <= '0;
         data_q   <= 16'h0000;
         points_q <= 4'h0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         dwell_q  <= dwell_d;
         grant_q  <= grant_d;
         data_q   <= data_d;
         points_q <= points_d;
         pulse_q  <= pulse_d;
      end
   end

   assign grant         = grant_q;
   assign grantIndex    = owner_q;
   assign displayData   = data_q;
   assign displayPoints = points_q;
   assign switchPulse   = pulse_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Scenario bench for display_source_arbiter with 4 sources and a dwell of 4 cycles;
// expected outputs are queued when stimulus is applied and compared one edge later.
module tb_display_source_arbiter;

   localparam int N = 4;
   localparam int D = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    request = 4'b0000;
   logic [63:0]   sourceData;
   logic [15:0]   sourcePoints;
   logic          hold = 1'b0;
   logic [15:0]   displayData;
   logic [3:0]    displayPoints;
   logic [3:0]    grant;
   logic [1:0]    grantIndex;
   logic          switchPulse;

   logic [26:0]   exp_q [$];
   logic [26:0]   got;
   logic [26:0]   want;
   int            checks = 0;
   int            fails  = 0;

   display_source_arbiter #(.NUM_SOURCES(N), .DWELL_CYCLES(D)) dut (
      .clock         (clock),
      .reset         (reset),
      .request       (request),
      .sourceData    (sourceData),
      .sourcePoints  (sourcePoints),
      .hold          (hold),
      .displayData   (displayData),
      .displayPoints (displayPoints),
      .grant         (grant),
      .grantIndex    (grantIndex),
      .switchPulse   (switchPulse)
   );

   always #5 clock = ~clock;

   // Packed expectation {grant, grantIndex, displayData, displayPoints, switchPulse} for owner s (-1 = idle).
   function automatic logic [26:0] ex(input int s, input logic pl);
      logic [15:0] dt [4];
      logic [3:0]  pt [4];
      logic [3:0]  one;
      dt  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
      pt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      one = 4'b0001;
      if (s < 0) return {4'b0000, 2'b00, 16'h0000, 4'b0000, pl};
      return {one << s, 2'(s), dt[s], pt[s], pl};
   endfunction

   task automatic load_default_data();
      sourceData   = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
      sourcePoints = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
   endtask

   task automatic drive(input logic [3:0] r, input logic h, input logic [26:0] e);
      request = r;
      hold    = h;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      request = 4'b0000;
      hold    = 1'b0;
      load_default_data();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      load_default_data();
      drive(4'b1111, 1'b0, ex(-1, 1'b0));
      reset = 1'b0;
      for (int c = 0; c <= 10; c++) begin
         if (c > 0) drive(4'b0000, 1'b0, ex(-1, 1'b0));
         got  = {grant, grantIndex, displayData, displayPoints, switchPulse};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            fails++;
            $display("FAIL reset_idle cycle %0d: got %h required %h", c, got, want);
         end
      end
   endtask

   task automatic test_rotation();
      int own [10] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0};
      do_reset();
      for (int c = 0; c < 10; c++) begin
         drive(4'b0101, 1'b0, ex(own[c], (c == 0) || (c == 4) || (c == 8)));
         got  = {grant, grantIndex, displayData, displayPoints, switchPulse};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            fails++;
            $display("FAIL rotation cycle %0d: got %h required %h", c + 1, got, want);
         end
      end
   endtask

   task automatic test_owner_drop();
      logic [3:0] req [7] = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
      int         own [7] = '{0, 0, 3, 3, 3, -1, -1};
      logic       pl  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      for (int c = 0; c < 7; c++) begin
         drive(req[c], 1'b0, ex(own[c], pl[c]));
         got  = {grant, grantIndex, displayData, displayPoints, switchPulse};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            fails++;
            $display("FAIL owner_drop cycle %0d: got %h required %h", c + 1, got, want);
         end
      end
   endtask

   task automatic test_hold();
      do_reset();
      for (int c = 0; c < 15; c++) begin
         if (c < 12)       drive(4'b0011, 1'b1, ex(0, c == 0));
         else if (c == 12) drive(4'b0011, 1'b0, ex(1, 1'b1));
         else if (c == 13) drive(4'b0011, 1'b1, ex(1, 1'b0));
         else              drive(4'b0001, 1'b1, ex(0, 1'b1));
         got  = {grant, grantIndex, displayData, displayPoints, switchPulse};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            fails++;
            $display("FAIL hold cycle %0d: got %h required %h", c + 1, got, want);
         end
      end
   endtask

   task automatic test_sole_owner();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c < 8) drive(4'b0100, 1'b0, ex(2, c == 0));
         else       drive(4'b0110, 1'b0, ex(1, c == 8));
         got  = {grant, grantIndex, displayData, displayPoints, switchPulse};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            fails++;
            $display("FAIL sole_owner cycle %0d: got %h required %h", c + 1, got, want);
         end
      end
   endtask

   task automatic test_data_tracking();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            sourceData[15:0]  = 16'hABCD;
            sourcePoints[3:0] = 4'b1010;
         end
         if (c == 3) begin
            sourceData[31:16] = 16'hFFFF;
            sourcePoints[7:4] = 4'b1111;
         end
         if (c < 2) drive(4'b0001, 1'b0, ex(0, c == 0));
         else       drive(4'b0001, 1'b0, {4'b0001, 2'd0, 16'hABCD, 4'b1010, 1'b0});
         got  = {grant, grantIndex, displayData, displayPoints, switchPulse};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            fails++;
            $display("FAIL data_tracking cycle %0d: got %h required %h", c + 1, got, want);
         end
      end
      load_default_data();
   endtask

   task automatic test_reset_mid_dwell();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         reset = (c == 2);
         if (c < 2)       drive(4'b0100, 1'b0, ex(2, c == 0));
         else if (c == 2) drive(4'b0100, 1'b0, ex(-1, 1'b0));
         else             drive(4'b0110, 1'b0, ex(1, c == 3));
         got  = {grant, grantIndex, displayData, displayPoints, switchPulse};
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            fails++;
            $display("FAIL reset_mid_dwell cycle %0d: got %h required %h", c + 1, got, want);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      load_default_data();
      test_reset();
      test_rotation();
      test_owner_drop();
      test_hold();
      test_sole_owner();
      test_data_tracking();
      test_reset_mid_dwell();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/display_source_arbiter.md
# display_source_arbiter

Time-shares the 4-digit seven-segment display among several requesters: a switch mirror, a counter, a status-message generator and others. Sources are granted in round-robin order. Each owner is guaranteed a minimum dwell time while others wait. The block sits between the requesters and the seven-segment controller and drives that controller's `data` and `pointEnable` inputs. It also provides a grant index for the LED indicators.

## Interface
- `NUM_SOURCES`, 4: number of requesters; legal range 2..8.
- `DWELL_CYCLES`, 100000000: minimum cycles an owner keeps the display under contention; must be ≥1.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `request`  in  NUM_SOURCES  bit i high: source i wants the display.
- `sourceData`  in  16*NUM_SOURCES  source i hex data at bits [16i+15:16i].
- `sourcePoints`  in  4*NUM_SOURCES  source i decimal-point mask at bits [4i+3:4i].
- `hold`  in  1  freezes rotation; owner keeps display past dwell expiry.
- `displayData`  out  16  registered data for the controller.
- `displayPoints`  out  4  registered point mask for the controller.
- `grant`  out  NUM_SOURCES  one-hot owner, or all-zero when idle.
- `grantIndex`  out  $clog2(NUM_SOURCES)  index of owner; 0 when idle.
- `switchPulse`  out  1  one-cycle pulse whenever `grant` changes value.

## Operation
- **State.** Two states.
  - IDLE: no owner.
  - OWNED: one owner, with a dwell counter `dwellCount` of width $clog2(DWELL_CYCLES+1).
- **Round-robin pointer.** `lastOwner` holds the last granted index.
  - Reset value is NUM_SOURCES-1, so the first search starts at source 0.
  - The search order is lastOwner+1, lastOwner+2, … modulo NUM_SOURCES.
- **IDLE → OWNED.** Taken when any `request` bit is set.
  - The first requesting index in search order is granted.
  - `dwellCount` is cleared to 0 and `lastOwner` is updated.
- **OWNED, owner request low.** Re-arbitrate immediately, with no dwell wait.
  - If another source is requesting, grant the next one in search order.
  - Otherwise go to IDLE.
- **OWNED, owner request high.** `dwellCount` increments each cycle, saturating at DWELL_CYCLES-1.
- **Rotation on dwell expiry.** When all three hold:
  - `dwellCount` == DWELL_CYCLES-1,
  - `hold` is 0,
  - at least one other source is requesting,
  
  then the next requester in search order after the owner is granted and `dwellCount` is cleared.
- **Sole requester.** If the owner is the only requester at expiry, it keeps the display. No pulse is generated and the counter stays saturated. A later competing request causes a switch on the next edge.
- **`hold`.** Suppresses only dwell-expiry rotation. An owner dropping its request still releases the display while `hold` is high.
- **Display outputs.**
  - `displayData` and `displayPoints` are registered copies of the current owner's slices, updated every cycle.
  - In IDLE both are 0, so the display shows "0000" with no points.
- **`switchPulse`.** High for exactly the cycle in which registered `grant` differs from its previous value, including a change to idle.
- **Reset.** Values at the clock edge where `reset` is sampled high, regardless of state:
  - `grant` = 0, `grantIndex` = 0
  - `displayData` = 0, `displayPoints` = 0
  - `switchPulse` = 0, `dwellCount` = 0
  - `lastOwner` = NUM_SOURCES-1
  
  Reset takes priority over all requests.

## Timing
- A request rising in cycle t while IDLE gives `grant`, `grantIndex`, display outputs and `switchPulse` valid in cycle t+1.
- Under contention an owner holds the display exactly DWELL_CYCLES cycles. If granted at cycle g, the next owner appears at cycle g+DWELL_CYCLES.
- An owner dropping `request` in cycle t gives the new `grant` in cycle t+1.
- A change in the owner's `sourceData`/`sourcePoints` in cycle t appears on the display outputs in cycle t+1. Changes from non-owners are ignored.
- `hold` falling in cycle t with the counter saturated and contention present gives a switch in cycle t+1.
- With DWELL_CYCLES = 1, contended sources rotate every cycle.

## Test plan
The bench uses NUM_SOURCES = 4 and DWELL_CYCLES = 4.
- **Idle after reset.** Reset, then `request`=0 for 10 cycles → `grant`=0000, `displayData`=0x0000, `displayPoints`=0, `switchPulse` never high.
- **Contended rotation.** `request`=0101 from cycle 0 →
  - `grant`=0001 at cycle 1, with pulse;
  - `grant`=0100 at cycle 5, with pulse;
  - `grant`=0001 at cycle 9;
  - `grantIndex` tracks 0/2/0.
- **Owner drop.** Owner 0 granted at cycle 1; `request` changes to 1000 at cycle 2 → `grant`=1000 at cycle 3, `switchPulse` high at cycle 3 only.
- **Hold.** `request`=0011, `hold`=1 → source 0 still owns at cycle 12. Deassert `hold` at cycle 12 → `grant`=0010 at cycle 13.
- **Data tracking.** While source 0 owns, its data changes 0x1234→0xABCD at cycle t → `displayData`=0xABCD at t+1. Changing source 1's data does not affect the outputs.
- **Reset mid-dwell.** Source 2 owns and reset is asserted → all outputs are 0 on the next cycle. Then `request`=0110 → source 1 is granted, confirming the pointer was reset.
